// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the hardwired CPU sequencer: opcodes, step states,
// instruction classes and the per-class final execute step.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JAL  = 5'b10100;
    localparam logic [4:0] OP_JR   = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_MFHI = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;
    localparam logic [4:0] OP_IDLE = 5'b00000;

    typedef enum logic [3:0] {
        ST_RST  = 4'd0, ST_T0 = 4'd1, ST_T1 = 4'd2, ST_T2 = 4'd3, ST_T3 = 4'd4,
        ST_T4   = 4'd5, ST_T5 = 4'd6, ST_T6 = 4'd7, ST_T7 = 4'd8, ST_HALT = 4'd9
    } state_e;

    typedef enum logic [3:0] {
        CL_ALU_R, CL_ALU_I, CL_LD, CL_LDI, CL_ST, CL_MULDIV, CL_UNARY, CL_BR,
        CL_JR, CL_JAL, CL_IN, CL_OUT, CL_MFLO, CL_MFHI, CL_NOP, CL_HALT
    } iclass_e;

    // Final execute step of each class; the sequencer returns to T0 after it.
    function automatic state_e last_step(input iclass_e c);
        case (c)
            CL_ALU_R, CL_ALU_I, CL_LDI: last_step = ST_T5;
            CL_LD, CL_ST:               last_step = ST_T7;
            CL_MULDIV, CL_BR:           last_step = ST_T6;
            CL_UNARY, CL_JAL:           last_step = ST_T4;
            default:                    last_step = ST_T3;
        endcase
    endfunction

endpackage

// File: rtl/op_classifier.sv
// Combinational opcode-to-class decoder; unused codes fall into the nop class.
module op_classifier
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0] op,
    output iclass_e    op_class
);

    // Map each opcode onto the execute sequence it shares with its siblings.
    always_comb begin
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
            OP_SHR, OP_SHRA, OP_SHL:   op_class = CL_ALU_R;
            OP_ADDI, OP_ANDI, OP_ORI:  op_class = CL_ALU_I;
            OP_LD:                     op_class = CL_LD;
            OP_LDI:                    op_class = CL_LDI;
            OP_ST:                     op_class = CL_ST;
            OP_MUL, OP_DIV:            op_class = CL_MULDIV;
            OP_NEG, OP_NOT:            op_class = CL_UNARY;
            OP_BR:                     op_class = CL_BR;
            OP_JR:                     op_class = CL_JR;
            OP_JAL:                    op_class = CL_JAL;
            OP_IN:                     op_class = CL_IN;
            OP_OUT:                    op_class = CL_OUT;
            OP_MFLO:                   op_class = CL_MFLO;
            OP_MFHI:                   op_class = CL_MFHI;
            OP_HALT:                   op_class = CL_HALT;
            default:                   op_class = CL_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer driving every datapath control line through
// fetch (T0-T2) and per-class execute steps (T3-T7).
module control_unit
    import cpu_ctrl_pkg::*;
(
    input  logic        Clock,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    output logic        run,
    output logic        PC_out, ZHigh_out, ZLow_out, HI_out, LO_out,
    output logic        C_out, MDR_out, BA_out, in_port_out,
    output logic        Gra, Grb, Grc, R_in, R_out,
    output logic        PC_enable, MAR_enable, MDR_enable, IR_enable, Y_enable,
    output logic        Z_enable, HI_enable, LO_enable, con_in, out_port_enable,
    output logic        RAM_write_enable,
    output logic        IncPC, Read,
    output logic [4:0]  opcode
);

    state_e     state_r, state_s;
    iclass_e    class_r, class_s;
    logic [4:0] op_r;
    logic       unused_ir_s;

    assign unused_ir_s = ^IR[26:0];

    op_classifier u_op_classifier (
        .op       (IR[31:27]),
        .op_class (class_s)
    );

    // Step register; clr forces RST asynchronously at any point.
    always_ff @(posedge Clock or negedge clr) begin
        if (!clr) begin
            state_r <= ST_RST;
        end else begin
            state_r <= state_s;
        end
    end

    // Instruction latch: class and opcode frozen at the end of T2.
    always_ff @(posedge Clock or negedge clr) begin
        if (!clr) begin
            class_r <= CL_NOP;
            op_r    <= OP_IDLE;
        end else if (state_r == ST_T2) begin
            class_r <= class_s;
            op_r    <= IR[31:27];
        end else begin
            class_r <= class_r;
            op_r    <= op_r;
        end
    end

    // Next-step selection.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_RST: state_s = ST_T0;
            ST_T0:  state_s = ST_T1;
            ST_T1:  state_s = ST_T2;
            ST_T2: begin
                if (class_s == CL_NOP) begin
                    state_s = ST_T0;
                end else if (class_s == CL_HALT) begin
                    state_s = ST_HALT;
                end else begin
                    state_s = ST_T3;
                end
            end
            ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
                if (state_r == last_step(class_r)) begin
                    state_s = ST_T0;
                end else begin
                    state_s = state_e'(state_r + 4'd1);
                end
            end
            ST_HALT: state_s = ST_HALT;
            default: state_s = ST_RST;
        endcase
    end

    // Control-word decode from step and latched class; only br T6 looks at CON_FF.
    always_comb begin
        run = (state_r != ST_RST) && (state_r != ST_HALT);
        {PC_out, ZHigh_out, ZLow_out, HI_out, LO_out, C_out, MDR_out, BA_out, in_port_out} = 9'd0;
        {Gra, Grb, Grc, R_in, R_out} = 5'd0;
        {PC_enable, MAR_enable, MDR_enable, IR_enable, Y_enable, Z_enable} = 6'd0;
        {HI_enable, LO_enable, con_in, out_port_enable, RAM_write_enable} = 5'd0;
        {IncPC, Read} = 2'd0;
        opcode = OP_IDLE;
        case (state_r)
            ST_T0: begin PC_out = 1'b1; MAR_enable = 1'b1; IncPC = 1'b1; Z_enable = 1'b1; end
            ST_T1: begin ZLow_out = 1'b1; PC_enable = 1'b1; Read = 1'b1; MDR_enable = 1'b1; end
            ST_T2: begin MDR_out = 1'b1; IR_enable = 1'b1; end
            ST_T3: begin
                case (class_r)
                    CL_ALU_R:  begin Grb = 1'b1; R_out = 1'b1; Y_enable = 1'b1; end
                    CL_ALU_I, CL_LD, CL_LDI, CL_ST:
                               begin Grb = 1'b1; BA_out = 1'b1; Y_enable = 1'b1; end
                    CL_MULDIV: begin Gra = 1'b1; R_out = 1'b1; Y_enable = 1'b1; end
                    CL_UNARY:  begin Grb = 1'b1; R_out = 1'b1; opcode = op_r; Z_enable = 1'b1; end
                    CL_BR:     begin Gra = 1'b1; R_out = 1'b1; con_in = 1'b1; end
                    CL_JR:     begin Gra = 1'b1; R_out = 1'b1; PC_enable = 1'b1; end
                    CL_JAL:    begin PC_out = 1'b1; Grb = 1'b1; R_in = 1'b1; end
                    CL_IN:     begin in_port_out = 1'b1; Gra = 1'b1; R_in = 1'b1; end
                    CL_OUT:    begin Gra = 1'b1; R_out = 1'b1; out_port_enable = 1'b1; end
                    CL_MFLO:   begin LO_out = 1'b1; Gra = 1'b1; R_in = 1'b1; end
                    CL_MFHI:   begin HI_out = 1'b1; Gra = 1'b1; R_in = 1'b1; end
                    default:   begin end
                endcase
            end
            ST_T4: begin
                case (class_r)
                    CL_ALU_R:  begin Grc = 1'b1; R_out = 1'b1; opcode = op_r; Z_enable = 1'b1; end
                    CL_ALU_I:  begin C_out = 1'b1; opcode = op_r; Z_enable = 1'b1; end
                    CL_LD, CL_LDI, CL_ST:
                               begin C_out = 1'b1; opcode = OP_ADD; Z_enable = 1'b1; end
                    CL_MULDIV: begin Grb = 1'b1; R_out = 1'b1; opcode = op_r; Z_enable = 1'b1; end
                    CL_UNARY:  begin ZLow_out = 1'b1; Gra = 1'b1; R_in = 1'b1; end
                    CL_BR:     begin PC_out = 1'b1; Y_enable = 1'b1; end
                    CL_JAL:    begin Gra = 1'b1; R_out = 1'b1; PC_enable = 1'b1; end
                    default:   begin end
                endcase
            end
            ST_T5: begin
                case (class_r)
                    CL_ALU_R, CL_ALU_I, CL_LDI:
                               begin ZLow_out = 1'b1; Gra = 1'b1; R_in = 1'b1; end
                    CL_LD, CL_ST:
                               begin ZLow_out = 1'b1; MAR_enable = 1'b1; end
                    CL_MULDIV: begin ZLow_out = 1'b1; LO_enable = 1'b1; end
                    CL_BR:     begin C_out = 1'b1; opcode = OP_ADD; Z_enable = 1'b1; end
                    default:   begin end
                endcase
            end
            ST_T6: begin
                case (class_r)
                    CL_LD:     begin Read = 1'b1; MDR_enable = 1'b1; end
                    CL_ST:     begin Gra = 1'b1; R_out = 1'b1; MDR_enable = 1'b1; end
                    CL_MULDIV: begin ZHigh_out = 1'b1; HI_enable = 1'b1; end
                    CL_BR:     begin ZLow_out = 1'b1; PC_enable = CON_FF; end
                    default:   begin end
                endcase
            end
            ST_T7: begin
                case (class_r)
                    CL_LD:     begin MDR_out = 1'b1; Gra = 1'b1; R_in = 1'b1; end
                    CL_ST:     begin RAM_write_enable = 1'b1; end
                    default:   begin end
                endcase
            end
            default: begin end
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench: a queue of expected control words per cycle, built from
// the instruction rules, compared every cycle, plus a few literal pin checks.
module tb_control_unit;

    logic        Clock, clr, CON_FF;
    logic [31:0] IR;
    logic        run, PC_out, ZHigh_out, ZLow_out, HI_out, LO_out, C_out, MDR_out, BA_out, in_port_out;
    logic        Gra, Grb, Grc, R_in, R_out;
    logic        PC_enable, MAR_enable, MDR_enable, IR_enable, Y_enable, Z_enable;
    logic        HI_enable, LO_enable, con_in, out_port_enable, RAM_write_enable, IncPC, Read;
    logic [4:0]  opcode;

    control_unit dut (
        .Clock(Clock), .clr(clr), .IR(IR), .CON_FF(CON_FF), .run(run),
        .PC_out(PC_out), .ZHigh_out(ZHigh_out), .ZLow_out(ZLow_out), .HI_out(HI_out),
        .LO_out(LO_out), .C_out(C_out), .MDR_out(MDR_out), .BA_out(BA_out),
        .in_port_out(in_port_out), .Gra(Gra), .Grb(Grb), .Grc(Grc), .R_in(R_in),
        .R_out(R_out), .PC_enable(PC_enable), .MAR_enable(MAR_enable),
        .MDR_enable(MDR_enable), .IR_enable(IR_enable), .Y_enable(Y_enable),
        .Z_enable(Z_enable), .HI_enable(HI_enable), .LO_enable(LO_enable),
        .con_in(con_in), .out_port_enable(out_port_enable),
        .RAM_write_enable(RAM_write_enable), .IncPC(IncPC), .Read(Read), .opcode(opcode)
    );

    localparam logic [32:0] M_PCO = 33'd1 << 0,  M_ZHI = 33'd1 << 1,  M_ZLO = 33'd1 << 2;
    localparam logic [32:0] M_HIO = 33'd1 << 3,  M_LOO = 33'd1 << 4,  M_CO  = 33'd1 << 5;
    localparam logic [32:0] M_MDO = 33'd1 << 6,  M_BA  = 33'd1 << 7,  M_INP = 33'd1 << 8;
    localparam logic [32:0] M_GA  = 33'd1 << 9,  M_GB  = 33'd1 << 10, M_GC  = 33'd1 << 11;
    localparam logic [32:0] M_RIN = 33'd1 << 12, M_ROUT = 33'd1 << 13, M_PCE = 33'd1 << 14;
    localparam logic [32:0] M_MAR = 33'd1 << 15, M_MDE = 33'd1 << 16, M_IRE = 33'd1 << 17;
    localparam logic [32:0] M_YE  = 33'd1 << 18, M_ZE  = 33'd1 << 19, M_HIE = 33'd1 << 20;
    localparam logic [32:0] M_LOE = 33'd1 << 21, M_CON = 33'd1 << 22, M_OPE = 33'd1 << 23;
    localparam logic [32:0] M_RAM = 33'd1 << 24, M_INC = 33'd1 << 25, M_RD  = 33'd1 << 26;
    localparam logic [32:0] M_RUN = 33'd1 << 27;

    logic [32:0] dut_word;
    assign dut_word = {opcode, run, Read, IncPC, RAM_write_enable, out_port_enable, con_in,
                       LO_enable, HI_enable, Z_enable, Y_enable, IR_enable, MDR_enable,
                       MAR_enable, PC_enable, R_out, R_in, Grc, Grb, Gra, in_port_out,
                       BA_out, MDR_out, C_out, LO_out, HI_out, ZLow_out, ZHigh_out, PC_out};

    typedef struct {
        logic [31:0] ir;
        logic        con;
        logic [32:0] word;
        int          pin;
        int          stp;
    } ent_t;

    ent_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] cur_ir;
    logic        cur_con;
    int          cur_stp;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [32:0] opw(input logic [4:0] o);
        opw = {o, 28'd0};
    endfunction

    task automatic push_raw(input logic [32:0] w, input int pin);
        ent_t e;
        e.ir = cur_ir; e.con = cur_con; e.word = w; e.pin = pin; e.stp = cur_stp;
        q.push_back(e);
        cur_stp++;
    endtask

    task automatic push_w(input logic [32:0] w);
        push_raw(w | M_RUN, 0);
    endtask

    task automatic set_pin(input int back, input int p);
        q[q.size() - back].pin = p;
    endtask

    // Expected per-cycle control words for one instruction, fetch included.
    task automatic push_instr(input logic [4:0] op, input logic con);
        cur_ir = {op, 27'h12345A7}; cur_con = con; cur_stp = 0;
        push_w(M_PCO | M_MAR | M_INC | M_ZE);
        push_w(M_ZLO | M_PCE | M_RD | M_MDE);
        push_w(M_MDO | M_IRE);
        if (op inside {[5'd3:5'd11]}) begin
            push_w(M_GB | M_ROUT | M_YE);
            push_w(M_GC | M_ROUT | opw(op) | M_ZE);
            push_w(M_ZLO | M_GA | M_RIN);
        end else if (op inside {[5'd12:5'd14]}) begin
            push_w(M_GB | M_BA | M_YE);
            push_w(M_CO | opw(op) | M_ZE);
            push_w(M_ZLO | M_GA | M_RIN);
        end else if (op inside {[5'd0:5'd2]}) begin
            push_w(M_GB | M_BA | M_YE);
            push_w(M_CO | opw(5'b00011) | M_ZE);
            if (op == 5'd1) begin
                push_w(M_ZLO | M_GA | M_RIN);
            end else begin
                push_w(M_ZLO | M_MAR);
                if (op == 5'd0) begin
                    push_w(M_RD | M_MDE);
                    push_w(M_MDO | M_GA | M_RIN);
                end else begin
                    push_w(M_GA | M_ROUT | M_MDE);
                    push_w(M_RAM);
                end
            end
        end else if (op == 5'd15 || op == 5'd16) begin
            push_w(M_GA | M_ROUT | M_YE);
            push_w(M_GB | M_ROUT | opw(op) | M_ZE);
            push_w(M_ZLO | M_LOE);
            push_w(M_ZHI | M_HIE);
        end else if (op == 5'd17 || op == 5'd18) begin
            push_w(M_GB | M_ROUT | opw(op) | M_ZE);
            push_w(M_ZLO | M_GA | M_RIN);
        end else if (op == 5'd19) begin
            push_w(M_GA | M_ROUT | M_CON);
            push_w(M_PCO | M_YE);
            push_w(M_CO | opw(5'b00011) | M_ZE);
            push_w(M_ZLO | (con ? M_PCE : 33'd0));
        end else if (op == 5'd20) begin
            push_w(M_PCO | M_GB | M_RIN);
            push_w(M_GA | M_ROUT | M_PCE);
        end else if (op == 5'd21) push_w(M_GA | M_ROUT | M_PCE);
        else if (op == 5'd22)     push_w(M_INP | M_GA | M_RIN);
        else if (op == 5'd23)     push_w(M_GA | M_ROUT | M_OPE);
        else if (op == 5'd24)     push_w(M_LOO | M_GA | M_RIN);
        else if (op == 5'd25)     push_w(M_HIO | M_GA | M_RIN);
        else                      cur_stp = cur_stp;
    endtask

    task automatic pin_check(input string name, input logic [32:0] got, input logic [32:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // Per-cycle compare: apply the entry's IR/CON_FF, then check the outputs.
    initial begin : compare
        ent_t e;
        IR = 32'd0; CON_FF = 1'b0;
        forever begin
            @(negedge Clock);
            if (q.size() > 0) begin
                e = q.pop_front();
                IR = e.ir; CON_FF = e.con;
                #1;
                checks++;
                if (dut_word !== e.word) begin
                    errors++;
                    $display("FAIL ctrl op=%b step=%0d: got %h, required %h",
                             e.ir[31:27], e.stp, dut_word, e.word);
                end
                case (e.pin)
                    1: pin_check("ori_T4", {28'd0, opcode, C_out, Z_enable}, {28'd0, 5'b01110, 2'b11});
                    2: pin_check("st_T7", {31'd0, RAM_write_enable, Read}, {31'd0, 2'b10});
                    3: pin_check("br_taken_T6", {32'd0, PC_enable}, 33'd1);
                    4: pin_check("br_not_taken_T6", {32'd0, PC_enable}, 33'd0);
                    5: pin_check("mul_T4_op", {28'd0, opcode}, {28'd0, 5'b10000});
                    6: pin_check("mul_T6_hi", {32'd0, HI_enable}, 33'd1);
                    7: pin_check("halt_frozen", dut_word, 33'd0);
                    default: begin end
                endcase
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 1000) begin
            @(negedge Clock); #3;
            n++;
        end
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d entries left, required 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        clr = 1'b0;
        repeat (3) @(negedge Clock);
        #1 pin_check("reset_state", dut_word, 33'd0);

        @(negedge Clock); #2 clr = 1'b1;
        push_instr(5'b01110, 1'b0); set_pin(2, 1);
        push_instr(5'b00000, 1'b0);
        push_instr(5'b00010, 1'b0); set_pin(1, 2);
        push_instr(5'b00011, 1'b1);
        push_instr(5'b10011, 1'b0); set_pin(1, 4);
        push_instr(5'b10011, 1'b1); set_pin(1, 3);
        push_instr(5'b10000, 1'b0); set_pin(3, 5); set_pin(1, 6);
        push_instr(5'b11110, 1'b1);
        push_instr(5'b11010, 1'b0);
        push_instr(5'b10101, 1'b0);
        push_instr(5'b10100, 1'b1);
        push_instr(5'b10110, 1'b0);
        push_instr(5'b10111, 1'b0);
        push_instr(5'b11000, 1'b0);
        push_instr(5'b11001, 1'b0);
        push_instr(5'b10001, 1'b1);
        push_instr(5'b10010, 1'b0);
        push_instr(5'b01111, 1'b0);
        push_instr(5'b01101, 1'b0);
        push_instr(5'b00001, 1'b0);
        push_instr(5'b00100, 1'b1);
        push_instr(5'b01001, 1'b0);
        drain();

        // Abort an add in the middle of T4.
        push_instr(5'b00011, 1'b0);
        n = 0;
        while (q.size() > 1 && n < 100) begin
            @(negedge Clock); #3;
            n++;
        end
        clr = 1'b0;
        q.delete();
        #1 pin_check("async_clear_mid_T4", dut_word, 33'd0);
        @(negedge Clock); #2 clr = 1'b1;
        push_instr(5'b00011, 1'b0);
        push_instr(5'b11011, 1'b0);
        for (int i = 0; i < 20; i++) push_raw(33'd0, 7);
        drain();

        // Only clr leaves HALT.
        clr = 1'b0;
        #1 pin_check("clear_in_halt", dut_word, 33'd0);
        @(negedge Clock); #2 clr = 1'b1;
        push_instr(5'b11010, 1'b0);
        push_instr(5'b00101, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
